// File: rtl/mcs4_shifter_ext_if.sv
// Bus bundle for the MCS-4 shifter/expander: the serial, parallel and strobe pins
// that the CPU I/O port bits drive, and the outputs that the expander returns.
interface mcs4_shifter_ext_if #(
  parameter int WIDTH = 10
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             SCK;
  logic             SDI;
  logic             DIR;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic             STB;
  logic             OE;
  logic             SDO;
  logic [WIDTH-1:0] Q;
  logic [CW-1:0]    CNT;
  logic             FULL;

  modport master (
    output SCK, SDI, DIR, LOAD, D, STB, OE,
    input  SDO, Q, CNT, FULL
  );

  modport slave (
    input  SCK, SDI, DIR, LOAD, D, STB, OE,
    output SDO, Q, CNT, FULL
  );
endinterface

// File: rtl/mcs4_shifter_ext.sv
// Parametrised i4003 successor: a bidirectional shift register with parallel load,
// a strobe-latched hold stage, and a saturating shift counter that drives FULL.
module mcs4_shifter_ext #(
  parameter int WIDTH   = 10,
  parameter int SYNC_EN = 0,
  parameter int LATCHED = 1
) (
  input logic               CLK,
  input logic               RES_N,
  mcs4_shifter_ext_if.slave bus
);
  localparam int            CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic             sck_s;
  logic             stb_s;
  logic             sck_d;
  logic             stb_d;
  logic             shift_ev;
  logic             stb_ev;
  logic [WIDTH-1:0] sft;
  logic [WIDTH-1:0] sft_nxt;
  logic [WIDTH-1:0] q_src;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;

  // SCK and STB are software-toggled levels, not clocks. There is no valid/ready
  // handshake: each low-to-high transition seen on CLK is one event, and a level
  // held high yields exactly one event.
  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [1:0] sck_sync;
      logic [1:0] stb_sync;

      always_ff @(posedge CLK) begin
        if (!RES_N) begin
          sck_sync <= 2'b00;
          stb_sync <= 2'b00;
        end else begin
          sck_sync <= {sck_sync[0], bus.SCK};
          stb_sync <= {stb_sync[0], bus.STB};
        end
      end

      assign sck_s = sck_sync[1];
      assign stb_s = stb_sync[1];
    end else begin : g_direct
      assign sck_s = bus.SCK;
      assign stb_s = bus.STB;
    end
  endgenerate

  // The delay flops clear on reset, so a SCK already high at reset release
  // still counts as one edge.
  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      sck_d <= 1'b0;
      stb_d <= 1'b0;
    end else begin
      sck_d <= sck_s;
      stb_d <= stb_s;
    end
  end

  assign shift_ev = sck_s & ~sck_d;
  assign stb_ev   = stb_s & ~stb_d;

  always_comb begin
    sft_nxt = sft;
    if (bus.LOAD) begin
      sft_nxt = bus.D;
    end else if (shift_ev) begin
      if (bus.DIR) sft_nxt = {bus.SDI, sft[WIDTH-1:1]};
      else         sft_nxt = {sft[WIDTH-2:0], bus.SDI};
    end
  end

  // A shift that coincides with STB opens the new frame, so it counts as 1.
  always_comb begin
    cnt_nxt = cnt;
    if (bus.LOAD) begin
      cnt_nxt = '0;
    end else if (stb_ev) begin
      cnt_nxt = shift_ev ? CW'(1) : '0;
    end else if (shift_ev && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      sft <= '0;
      cnt <= '0;
    end else begin
      sft <= sft_nxt;
      cnt <= cnt_nxt;
    end
  end

  generate
    if (LATCHED != 0) begin : g_latched
      logic [WIDTH-1:0] hold;

      // Captures the pre-update shift register, even if a shift or LOAD lands in the same cycle.
      always_ff @(posedge CLK) begin
        if (!RES_N)      hold <= '0;
        else if (stb_ev) hold <= sft;
      end

      assign q_src = hold;
    end else begin : g_live
      assign q_src = sft;
    end
  endgenerate

  assign bus.Q    = bus.OE ? q_src : '0;
  assign bus.SDO  = bus.DIR ? sft[0] : sft[WIDTH-1];
  assign bus.CNT  = cnt;
  assign bus.FULL = (cnt == CNT_MAX);
endmodule

// File: tb/tb_mcs4_shifter_ext.sv
// Directed bench for mcs4_shifter_ext: a latched instance, a live-Q instance that exposes
// the shift register, and a synchronized live-Q instance, all driven by the same inputs.
module tb_mcs4_shifter_ext;
  localparam int W = 10;

  logic         clk;
  logic         res_n;
  logic         sck;
  logic         sdi;
  logic         dir;
  logic         load;
  logic [W-1:0] d;
  logic         stb;
  logic         oe;

  int vectors;
  int miscompares;

  logic sdo_exp [10];

  mcs4_shifter_ext_if #(.WIDTH(W)) if_l ();
  mcs4_shifter_ext_if #(.WIDTH(W)) if_r ();
  mcs4_shifter_ext_if #(.WIDTH(W)) if_s ();

  assign if_l.SCK = sck;  assign if_r.SCK = sck;  assign if_s.SCK = sck;
  assign if_l.SDI = sdi;  assign if_r.SDI = sdi;  assign if_s.SDI = sdi;
  assign if_l.DIR = dir;  assign if_r.DIR = dir;  assign if_s.DIR = dir;
  assign if_l.LOAD = load; assign if_r.LOAD = load; assign if_s.LOAD = load;
  assign if_l.D = d;      assign if_r.D = d;      assign if_s.D = d;
  assign if_l.STB = stb;  assign if_r.STB = stb;  assign if_s.STB = stb;
  assign if_l.OE = oe;    assign if_r.OE = oe;    assign if_s.OE = oe;

  mcs4_shifter_ext #(.WIDTH(W), .SYNC_EN(0), .LATCHED(1)) dut_l (
    .CLK(clk), .RES_N(res_n), .bus(if_l.slave)
  );
  mcs4_shifter_ext #(.WIDTH(W), .SYNC_EN(0), .LATCHED(0)) dut_r (
    .CLK(clk), .RES_N(res_n), .bus(if_r.slave)
  );
  mcs4_shifter_ext #(.WIDTH(W), .SYNC_EN(1), .LATCHED(0)) dut_s (
    .CLK(clk), .RES_N(res_n), .bus(if_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic shift_bit(input logic b);
    sdi = b;
    sck = 1'b1;
    tick();
    sck = 1'b0;
    tick();
  endtask

  initial begin
    logic [9:0] seq;
    vectors     = 0;
    miscompares = 0;
    seq   = 10'b1011001011;
    sdo_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset with LOAD and STB high: reset must win.
    res_n = 1'b0; sck = 1'b0; sdi = 1'b0; dir = 1'b0;
    load = 1'b1; d = 10'h3FF; stb = 1'b1; oe = 1'b1;
    tick(); tick();
    check("reset_q_latched", 32'(if_l.Q), 32'h0);
    check("reset_q_live",    32'(if_r.Q), 32'h0);
    check("reset_cnt",       32'(if_l.CNT), 32'd0);
    check("reset_full",      32'(if_l.FULL), 32'd0);
    check("reset_sdo",       32'(if_l.SDO), 32'd0);
    load = 1'b0; stb = 1'b0; d = '0;
    res_n = 1'b1;
    tick();

    // DIR=0 frame: first bit ends at the MSB; Q stays held at 0.
    for (int i = 9; i >= 0; i--) begin
      shift_bit(seq[i]);
      if (i == 1) check("cnt_9_full", 32'(if_l.FULL), 32'd0);
    end
    check("dir0_sft",      32'(if_r.Q), 32'h2CB);
    check("dir0_q_held",   32'(if_l.Q), 32'h0);
    check("dir0_cnt",      32'(if_l.CNT), 32'd10);
    check("dir0_full",     32'(if_l.FULL), 32'd1);
    check("dir0_sdo",      32'(if_l.SDO), 32'd1);
    stb = 1'b1; tick(); stb = 1'b0; tick();
    check("stb_q",         32'(if_l.Q), 32'h2CB);
    check("stb_cnt",       32'(if_l.CNT), 32'd0);

    // DIR=1 frame: first bit ends at the LSB; SDO follows sft[0].
    dir = 1'b1;
    for (int k = 0; k < 10; k++) begin
      shift_bit(seq[9-k]);
      check($sformatf("dir1_sdo_%0d", k), 32'(if_l.SDO), 32'(sdo_exp[k]));
    end
    check("dir1_sft",      32'(if_r.Q), 32'h34D);
    check("dir1_cnt",      32'(if_l.CNT), 32'd10);
    shift_bit(1'b0);
    check("cnt_saturate",  32'(if_l.CNT), 32'd10);
    check("full_hold",     32'(if_l.FULL), 32'd1);

    // LOAD beats a coincident SCK edge.
    dir = 1'b0; d = 10'h3A5; load = 1'b1; sck = 1'b1;
    tick();
    load = 1'b0; sck = 1'b0;
    tick();
    check("load_sft",      32'(if_r.Q), 32'h3A5);
    check("load_cnt",      32'(if_l.CNT), 32'd0);
    check("load_sdo_pre",  32'(if_l.SDO), 32'd1);
    shift_bit(1'b0);
    check("load_shift",    32'(if_r.Q), 32'h34A);
    check("load_sdo_post", 32'(if_l.SDO), 32'd1);
    check("load_shift_cnt", 32'(if_l.CNT), 32'd1);

    // STB and SCK edge in the same cycle.
    d = 10'h155; load = 1'b1; tick(); load = 1'b0; tick();
    stb = 1'b1; sck = 1'b1; sdi = 1'b0;
    tick();
    check("coin_hold",     32'(if_l.Q), 32'h155);
    check("coin_sft",      32'(if_r.Q), 32'h2AA);
    check("coin_cnt",      32'(if_l.CNT), 32'd1);
    stb = 1'b0; sck = 1'b0;
    tick();
    oe = 1'b0; #1;
    check("oe_off",        32'(if_l.Q), 32'h0);
    oe = 1'b1; #1;
    check("oe_on",         32'(if_l.Q), 32'h155);

    // SCK held high: one shift; the synchronized instance lags by 2 cycles.
    d = '0; load = 1'b1;
    tick(); tick(); tick(); tick();
    load = 1'b0;
    tick();
    sdi = 1'b1; sck = 1'b1;
    tick();
    check("hold_live_t1",  32'(if_r.Q), 32'h001);
    check("hold_sync_t1",  32'(if_s.Q), 32'h000);
    tick();
    check("hold_sync_t2",  32'(if_s.Q), 32'h000);
    tick();
    check("hold_sync_t3",  32'(if_s.Q), 32'h001);
    tick(); tick();
    check("hold_live_t5",  32'(if_r.Q), 32'h001);
    check("hold_live_cnt", 32'(if_r.CNT), 32'd1);
    check("hold_sync_t5",  32'(if_s.Q), 32'h001);
    check("hold_sync_cnt", 32'(if_s.CNT), 32'd1);
    sck = 1'b0;
    tick(); tick(); tick();

    // Reset mid-frame, then release with SCK already high.
    d = 10'h3FF; load = 1'b1; tick(); load = 1'b0; tick();
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    check("mid_cnt",       32'(if_l.CNT), 32'd4);
    check("mid_sdo",       32'(if_l.SDO), 32'd1);
    check("mid_hold",      32'(if_l.Q), 32'h155);
    res_n = 1'b0;
    tick();
    check("mid_rst_q",     32'(if_l.Q), 32'h0);
    check("mid_rst_cnt",   32'(if_l.CNT), 32'd0);
    check("mid_rst_sdo",   32'(if_l.SDO), 32'd0);
    check("mid_rst_sft",   32'(if_r.Q), 32'h0);
    sck = 1'b1; sdi = 1'b1;
    tick();
    check("rst_beats_sck", 32'(if_r.Q), 32'h0);
    res_n = 1'b1;
    tick();
    check("rel_shift",     32'(if_r.Q), 32'h001);
    tick(); tick();
    check("rel_once",      32'(if_r.Q), 32'h001);
    check("rel_cnt",       32'(if_r.CNT), 32'd1);
    sck = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mcs4_shifter_ext.md
Name: mcs4_shifter_ext

Overview:
Parametrised successor to the i4003 10-bit shift register, used as the MCS-4 output expander and keyboard-scan register.
- Adds a configurable width and selectable shift direction.
- Adds parallel load for PISO keyboard capture.
- Adds a strobe-latched output stage so outputs do not ripple during shifting, plus a shift counter with a FULL flag.
- Sits on the CPU I/O port bits, driven by software-toggled SCK/SDI/STB; cascadable through SDO.

Parameters:
WIDTH, 10, number of shift/output bits (2..32).
SYNC_EN, 0, 1 inserts a 2-flop synchronizer on SCK and STB; 0 samples them directly.
LATCHED, 1, 1 drives Q from the strobe-latched hold register; 0 drives Q from the live shift register (i4003-compatible).

Ports:
CLK  input  1  system clock; all state updates on its rising edge.
RES_N  input  1  reset; synchronous, active-low, sampled on the rising edge of CLK.
SCK  input  1  shift clock; one shift per detected rising edge.
SDI  input  1  serial data in.
DIR  input  1  0: shift toward MSB (SDI enters bit 0); 1: shift toward LSB (SDI enters bit WIDTH-1).
LOAD  input  1  level, CLK-synchronous; loads D into the shift register.
D  input  WIDTH  parallel load data.
STB  input  1  strobe; its rising edge copies the shift register into the hold register.
OE  input  1  output enable.
SDO  output  1  serial out: sft[WIDTH-1] when DIR=0, sft[0] when DIR=1.
Q  output  WIDTH  parallel output; all zero when OE=0.
CNT  output  clog2(WIDTH+1)  shift edges since last LOAD/STB, saturating at WIDTH.
FULL  output  1  CNT==WIDTH.

Behaviour:
- Reset (RES_N=0 at a CLK edge) clears:
  - sft, hold and CNT to 0;
  - the SCK/STB delay and synchronizer flops to 0.
  - Consequences: Q=0, SDO=0, FULL=0. Reset wins over every other input in that cycle, including mid-shift.
- Edge detect:
  - sck_s is SCK, or SCK after 2 CLK stages when SYNC_EN=1.
  - sck_d is sck_s delayed 1 CLK.
  - A shift event is sck_s & ~sck_d. STB is detected the same way.
  - SCK held high produces only one event. The first SCK high after reset counts as an edge.
- Latency, SYNC_EN=0: SCK sampled high at CLK edge n (low at n-1) means the new sft is visible after edge n. SYNC_EN=1 adds 2 cycles.
- Shift:
  - DIR=0: sft <= {sft[WIDTH-2:0], SDI}.
  - DIR=1: sft <= {SDI, sft[WIDTH-1:1]}.
  - DIR is sampled in the same cycle as the event.
  - SDO is combinational from sft and DIR.
- LOAD=1 at an edge: sft <= D and CNT <= 0.
  - LOAD has priority over a shift event in the same cycle; that shift is dropped.
  - LOAD does not touch hold.
- STB event: hold <= sft (the pre-update value if a shift or LOAD occurs in the same cycle), and CNT <= 0.
- CNT update priority per cycle: reset > LOAD > STB > shift.
  - If STB and a shift coincide, CNT <= 1 (the shift is counted in the new frame).
  - CNT increments per shift event, saturating at WIDTH. FULL stays 1 until LOAD, STB or reset.
- Output:
  - LATCHED=1: Q = OE ? hold : 0.
  - LATCHED=0: Q = OE ? sft : 0, and STB affects only CNT.
  - OE is purely combinational gating; it never changes state.
- Cascade: SDO of stage k feeds SDI of stage k+1 with common SCK. Shift events occur on the same CLK edge, so the chain behaves as one WIDTH*N register.

Test Plan:
- Reset, then WIDTH=10, DIR=0, OE=1, LATCHED=1, SYNC_EN=0. Shift SDI 1,0,1,1,0,0,1,0,1,1 (first bit first) → sft=10'b1011001011, Q stays 0, CNT=10, FULL=1. Then STB pulse → Q=10'h2CB, CNT=0.
- Same sequence with DIR=1 → sft=10'b1101001101; SDO tracks sft[0] after each shift.
- LOAD=1, D=10'h3A5, with an SCK rising edge in the same cycle → sft=10'h3A5, CNT=0 (shift dropped). Then one shift with SDI=0 and DIR=0 → sft=10'h34A, SDO=1 before the shift and 1 after.
- STB and an SCK edge coincide with sft=10'h155, SDI=0, DIR=0 → hold=10'h155, sft=10'h2AA, CNT=1. Toggle OE=0 → Q=0; OE=1 → Q=10'h155.
- SCK held high 5 cycles → exactly one shift. With SYNC_EN=1 the shift appears 2 cycles later than with SYNC_EN=0.
- Assert RES_N=0 for one edge mid-frame (CNT=4, hold nonzero) → next cycle Q=0, CNT=0, SDO=0. Deassert RES_N while SCK is already high → exactly one shift, since sck_d resets to 0.
